// File: rtl/acc_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acc_seq_pkg
//  Description : Shared types and constants for the accumulate sequencer:
//                command opcodes, FSM states and saturation limits.
//  Revision    : 1.0  initial release
// ============================================================================
package acc_seq_pkg;

    // Command opcodes as they appear on cmd_op
    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_LOAD = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Signed saturation limits for an 8-bit accumulator
    localparam logic [7:0] SAT_POS = 8'h7F;
    localparam logic [7:0] SAT_NEG = 8'h80;

    // True when the op streams operands through the datapath
    function automatic logic op_has_operands(input op_e op);
        return (op != OP_CLR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/as8b.sv
`default_nettype none
// ============================================================================
//  Module      : as8b
//  Description : 8-bit combinational adder with carry-in, carry-out and
//                two's-complement overflow flag. Subtraction is done by the
//                caller presenting ~B with carry-in set.
//  Ports       : i_a, i_b   8-bit operands
//                i_cin      carry-in
//                o_sum      8-bit sum
//                o_cout     carry-out of bit 7
//                o_v_flag   signed overflow (operands same sign, sum differs)
//  Revision    : 1.0  initial release
// ============================================================================
module as8b (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout,
    output logic       o_v_flag
);

    logic [8:0] w_full;

    assign w_full   = {1'b0, i_a} + {1'b0, i_b} + {8'b0, i_cin};
    assign o_sum    = w_full[7:0];
    assign o_cout   = w_full[8];
    assign o_v_flag = (i_a[7] == i_b[7]) && (w_full[7] != i_a[7]);

endmodule
`default_nettype wire

// File: rtl/acc_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : acc_seq_ctrl
//  Description : Command-driven sequencer for the 8-bit accumulate datapath.
//                Accepts one ADD/SUB/LOAD/CLR command with an operand count,
//                streams that many operands through one as8b adder, and
//                pulses done for one cycle on completion.
//  Ports       : clk_sys, rst_sys     clock / synchronous active-high reset
//                cmd_valid/cmd_ready  command handshake (cmd_op, cmd_cnt)
//                opd_valid/opd_ready  operand handshake (opd_data)
//                data_out             accumulator value
//                c_o                  carry-out of last executed step
//                overf                sticky overflow over current command
//                busy, done           status (done = one-cycle pulse)
//  Parameters  : WIDTH (only 8 legal), CNT_W, SAT_EN (1 = signed saturation)
//  Revision    : 1.0  initial release
// ============================================================================
module acc_seq_ctrl
    import acc_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 4,
    parameter int SAT_EN = 0
) (
    input  logic             clk_sys,
    input  logic             rst_sys,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             opd_valid,
    output logic             opd_ready,
    input  logic [WIDTH-1:0] opd_data,
    output logic [WIDTH-1:0] data_out,
    output logic             c_o,
    output logic             overf,
    output logic             busy,
    output logic             done
);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e           r_state;
    op_e              r_op;
    logic [CNT_W-1:0] r_rem;
    logic [WIDTH-1:0] r_acc;
    logic             r_c;
    logic             r_ovf;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    state_e           w_state_nxt;
    op_e              w_cmd_op;
    logic             w_cmd_acc;
    logic             w_opd_acc;
    logic             w_is_sub;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_v;
    logic [WIDTH-1:0] w_step_acc;

    assign w_cmd_op  = op_e'(cmd_op);
    assign w_cmd_acc = cmd_valid && cmd_ready;
    assign w_opd_acc = opd_valid && opd_ready;

    // ------------------------------------------------------------------
    // Adder: subtraction as A + ~B + 1 so c_o reads 1 when no borrow
    // ------------------------------------------------------------------
    assign w_is_sub = (r_op == OP_SUB);
    assign w_b      = w_is_sub ? ~opd_data : opd_data;

    as8b u_as8b (
        .i_a      (r_acc),
        .i_b      (w_b),
        .i_cin    (w_is_sub),
        .o_sum    (w_sum),
        .o_cout   (w_cout),
        .o_v_flag (w_v)
    );

    // Overflow direction follows the sign of the accumulator operand:
    // a positive A can only overflow upward, a negative A downward.
    always_comb begin
        w_step_acc = w_sum;
        if ((SAT_EN != 0) && w_v) begin
            w_step_acc = r_acc[WIDTH-1] ? SAT_NEG : SAT_POS;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        opd_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (!op_has_operands(w_cmd_op) || (cmd_cnt == '0)) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                opd_ready = 1'b1;
                // A zero remaining count can only be reached on the last
                // handshake; the second term keeps RUN from ever stalling.
                if ((opd_valid && (r_rem == CNT_W'(1))) || (r_rem == '0)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (rst_sys) begin
            r_op  <= OP_ADD;
            r_rem <= '0;
            r_acc <= '0;
            r_c   <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_cmd_acc) begin
            r_op  <= w_cmd_op;
            r_rem <= cmd_cnt;
            r_c   <= 1'b0;
            r_ovf <= 1'b0;
            if (w_cmd_op == OP_CLR) begin
                r_acc <= '0;
            end
        end else if (w_opd_acc) begin
            if (r_rem != '0) begin
                r_rem <= r_rem - CNT_W'(1);
            end
            case (r_op)
                OP_LOAD: begin
                    r_acc <= opd_data;
                end
                OP_ADD, OP_SUB: begin
                    r_acc <= w_step_acc;
                    r_c   <= w_cout;
                    r_ovf <= r_ovf | w_v;
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign data_out = r_acc;
    assign c_o      = r_c;
    assign overf    = r_ovf;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_acc_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_seq_ctrl
//  Description : Self-checking bench for acc_seq_ctrl. Drives a wrap-around
//                and a saturating instance with identical stimulus and
//                compares both against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_acc_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [3:0] cmd_cnt;
    logic       opd_valid;
    logic [7:0] opd_data;

    logic       cr0, or0, c0, ov0, busy0, done0;
    logic       cr1, or1, c1, ov1, busy1, done1;
    logic [7:0] dout0, dout1;

    int n_chk = 0;
    int n_err = 0;

    // Reference model (index 0 = wrap, 1 = saturate)
    int m_mode;   // 0 idle, 1 streaming operands, 2 completion cycle
    int m_rem;
    int m_op;
    int m_acc [2];
    int m_c   [2];
    int m_v   [2];

    acc_seq_ctrl #(.WIDTH(8), .CNT_W(4), .SAT_EN(0)) u_dut_wrap (
        .clk_sys(clk), .rst_sys(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cr0), .cmd_op(cmd_op), .cmd_cnt(cmd_cnt),
        .opd_valid(opd_valid), .opd_ready(or0), .opd_data(opd_data),
        .data_out(dout0), .c_o(c0), .overf(ov0), .busy(busy0), .done(done0)
    );

    acc_seq_ctrl #(.WIDTH(8), .CNT_W(4), .SAT_EN(1)) u_dut_sat (
        .clk_sys(clk), .rst_sys(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cr1), .cmd_op(cmd_op), .cmd_cnt(cmd_cnt),
        .opd_valid(opd_valid), .opd_ready(or1), .opd_data(opd_data),
        .data_out(dout1), .c_o(c1), .overf(ov1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic timeout(input string tag);
        n_chk++;
        n_err++;
        $display("FAIL %s timeout got=0x0 expected=0x1 at %0t", tag, $time);
    endtask

    // One arithmetic step using signed/unsigned integer arithmetic
    task automatic arith(input int op, input int a, input int b, input int sat,
                         output int res, output int c, output int v);
        int sa, sb, r;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        if (op == 0) begin
            r   = sa + sb;
            c   = ((a + b) > 255) ? 1 : 0;
            res = (a + b) & 255;
        end else begin
            r   = sa - sb;
            c   = (a >= b) ? 1 : 0;
            res = (a - b) & 255;
        end
        v = (r > 127 || r < -128) ? 1 : 0;
        if (sat != 0 && v != 0) res = (sa >= 0) ? 127 : 128;
    endtask

    task automatic model_edge();
        int res, c, v;
        if (rst) begin
            m_mode = 0;
            m_rem  = 0;
            for (int k = 0; k < 2; k++) begin
                m_acc[k] = 0; m_c[k] = 0; m_v[k] = 0;
            end
        end else if (m_mode == 0) begin
            if (cmd_valid) begin
                m_op  = int'(cmd_op);
                m_rem = int'(cmd_cnt);
                for (int k = 0; k < 2; k++) begin
                    m_c[k] = 0; m_v[k] = 0;
                    if (m_op == 3) m_acc[k] = 0;
                end
                m_mode = (m_op == 3 || m_rem == 0) ? 2 : 1;
            end
        end else if (m_mode == 1) begin
            if (opd_valid) begin
                m_rem--;
                for (int k = 0; k < 2; k++) begin
                    if (m_op == 2) begin
                        m_acc[k] = int'(opd_data);
                    end else begin
                        arith(m_op, m_acc[k], int'(opd_data), k, res, c, v);
                        m_acc[k] = res;
                        m_c[k]   = c;
                        m_v[k]   = m_v[k] | v;
                    end
                end
                if (m_rem == 0) m_mode = 2;
            end
        end else begin
            m_mode = 0;
        end
    endtask

    task automatic check_outs();
        chk("w_data",  int'(dout0), m_acc[0]);
        chk("w_c_o",   int'(c0),    m_c[0]);
        chk("w_overf", int'(ov0),   m_v[0]);
        chk("w_busy",  int'(busy0), (m_mode != 0) ? 1 : 0);
        chk("w_done",  int'(done0), (m_mode == 2) ? 1 : 0);
        chk("w_cmd_rdy", int'(cr0), (m_mode == 0) ? 1 : 0);
        chk("w_opd_rdy", int'(or0), (m_mode == 1) ? 1 : 0);
        chk("s_data",  int'(dout1), m_acc[1]);
        chk("s_c_o",   int'(c1),    m_c[1]);
        chk("s_overf", int'(ov1),   m_v[1]);
        chk("s_busy",  int'(busy1), (m_mode != 0) ? 1 : 0);
        chk("s_done",  int'(done1), (m_mode == 2) ? 1 : 0);
        chk("s_cmd_rdy", int'(cr1), (m_mode == 0) ? 1 : 0);
        chk("s_opd_rdy", int'(or1), (m_mode == 1) ? 1 : 0);
    endtask

    // Advance one clock with the currently driven inputs
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_outs();
    endtask

    task automatic send_cmd(input int op, input int cnt, input bit opd_noise);
        int guard = 0;
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_cnt   = 4'(cnt);
        opd_valid = opd_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        opd_data  = 8'($urandom);
        while (m_mode != 0 && guard < 20) begin
            step();
            guard++;
        end
        if (guard >= 20) timeout("cmd_accept");
        step();
        cmd_valid = 1'b0;
        opd_valid = 1'b0;
    endtask

    task automatic send_opd(input int data, input int gap, input bit cmd_noise);
        int guard = 0;
        for (int g = 0; g < gap; g++) begin
            opd_valid = 1'b0;
            cmd_valid = cmd_noise;
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_cnt   = 4'($urandom_range(0, 15));
            step();
        end
        cmd_valid = 1'b0;
        opd_valid = 1'b1;
        opd_data  = 8'(data);
        while (m_mode != 1 && guard < 20) begin
            step();
            guard++;
        end
        if (guard >= 20) timeout("opd_accept");
        step();
        opd_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (m_mode != 0 && guard < 20) begin
            step();
            guard++;
        end
        if (guard >= 20) timeout("drain");
    endtask

    initial begin
        int op, cnt;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_cnt = 4'd0;
        opd_valid = 1'b0; opd_data = 8'h00;
        m_mode = 0; m_rem = 0; m_op = 0;

        // 1: reset held two cycles
        step();
        step();
        chk("t1_data", int'(dout0), 0);
        chk("t1_busy", int'(busy0), 0);
        chk("t1_cmd_rdy", int'(cr0), 1);
        rst = 1'b0;

        // 2: ADD 10,20,30 back-to-back
        send_cmd(0, 3, 1'b0);
        send_opd(10, 0, 1'b0);
        send_opd(20, 0, 1'b0);
        send_opd(30, 0, 1'b0);
        chk("t2_done", int'(done0), 1);
        chk("t2_data", int'(dout0), 60);
        chk("t2_c_o",  int'(c0), 0);
        chk("t2_overf", int'(ov0), 0);
        drain();

        // 3: LOAD 5, SUB 7
        send_cmd(2, 1, 1'b0);
        send_opd(8'h05, 0, 1'b0);
        drain();
        send_cmd(1, 1, 1'b0);
        send_opd(8'h07, 0, 1'b0);
        chk("t3_data", int'(dout0), 8'hFE);
        chk("t3_c_o",  int'(c0), 0);
        chk("t3_overf", int'(ov0), 0);
        drain();

        // 4: LOAD 0x70, ADD 0x20, 0x01
        send_cmd(2, 1, 1'b0);
        send_opd(8'h70, 0, 1'b0);
        drain();
        send_cmd(0, 2, 1'b0);
        send_opd(8'h20, 0, 1'b0);
        chk("t4_sat_mid", int'(dout1), 8'h7F);
        chk("t4_wrap_mid", int'(dout0), 8'h90);
        send_opd(8'h01, 0, 1'b0);
        chk("t4_wrap_data", int'(dout0), 8'h91);
        chk("t4_wrap_overf", int'(ov0), 1);
        chk("t4_sat_data", int'(dout1), 8'h7F);
        chk("t4_sat_overf", int'(ov1), 1);
        drain();

        // 5: gaps of 3 cycles with command requests while busy
        send_cmd(3, 0, 1'b0);
        drain();
        send_cmd(0, 2, 1'b0);
        send_opd(8'h11, 3, 1'b1);
        chk("t5_mid_done", int'(done0), 0);
        chk("t5_mid_data", int'(dout0), 8'h11);
        send_opd(8'h22, 3, 1'b1);
        chk("t5_done", int'(done0), 1);
        chk("t5_data", int'(dout0), 8'h33);
        drain();

        // 6: reset after 1 of 3 operands, reset wins over same-edge handshake
        send_cmd(0, 3, 1'b0);
        send_opd(8'h44, 0, 1'b0);
        rst = 1'b1; opd_valid = 1'b1; opd_data = 8'h55;
        step();
        rst = 1'b0; opd_valid = 1'b0;
        chk("t6_data", int'(dout0), 0);
        chk("t6_busy", int'(busy0), 0);
        send_cmd(3, 5, 1'b0);
        chk("t6_clr_done", int'(done0), 1);
        drain();

        // Randomized commands
        for (int n = 0; n < 80; n++) begin
            op  = $urandom_range(0, 3);
            cnt = ($urandom_range(0, 7) == 0) ? $urandom_range(6, 15) : $urandom_range(0, 4);
            send_cmd(op, cnt, 1'($urandom_range(0, 1)));
            if (op != 3) begin
                for (int i = 0; i < cnt; i++) begin
                    send_opd($urandom_range(0, 255), $urandom_range(0, 2),
                             1'($urandom_range(0, 1)));
                end
            end
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
